// File: rtl/joy_serial_tx_pkg.sv
// Shared definitions for the serial joystick link; the host-side poller uses the same frame map.
// Build option JOY_TX_FILTER_EN enables the strobe agreement filter in joy_tx_sync (FILT_LEN deep).
package joy_serial_tx_pkg;

   localparam int FRAME_LEN = 24;
   localparam int FILT_LEN  = 3;
   localparam int JOY_W     = 12;
   localparam int CNT_W     = 5;
   localparam int SRC_W     = 5;

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_ARM   = 2'd2,
      ST_SHIFT = 2'd3
   } tx_state_t;

   // Frame bit i is taken from {joy2_n, joy1_n}[F_SRC[i]]; joy1 occupies 0..11, joy2 12..23.
   localparam logic [SRC_W-1:0] F_SRC [FRAME_LEN] = '{
      5'd8,  5'd6,  5'd5,  5'd4,  5'd3,  5'd2,  5'd1,  5'd0,
      5'd20, 5'd18, 5'd17, 5'd16, 5'd15, 5'd14, 5'd13, 5'd12,
      5'd22, 5'd23, 5'd21, 5'd19,
      5'd10, 5'd11, 5'd9,  5'd7
   };

   function automatic logic [FRAME_LEN-1:0] build_frame(input logic [JOY_W-1:0] j1,
                                                        input logic [JOY_W-1:0] j2);
      logic [2*JOY_W-1:0]   w_src;
      logic [FRAME_LEN-1:0] w_frame;
      w_src   = {j2, j1};
      w_frame = '1;
      for (int i = 0; i < FRAME_LEN; i++) begin
         w_frame[i] = w_src[F_SRC[i]];
      end
      return w_frame;
   endfunction

endpackage

// File: rtl/joy_serial_tx_sync.sv
// Strobe input path: 2-flop synchronizer, optional agreement filter (JOY_TX_FILTER_EN), registered rise pulse.
module joy_tx_sync
   import joy_serial_tx_pkg::*;
(
   input  logic clk12,
   input  logic reset_n,
   input  logic i_async,
   output logic o_level,
   output logic o_rise
);

   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic r_rise;
   logic w_level;

   always_ff @(posedge clk12 or negedge reset_n) begin
      if (!reset_n) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

`ifdef JOY_TX_FILTER_EN
   // Window = current synchronized sample plus the FILT_LEN-1 before it; level moves only on full agreement.
   logic [FILT_LEN-2:0] r_hist;
   logic                r_held;
   logic                w_all1;
   logic                w_all0;

   always_ff @(posedge clk12 or negedge reset_n) begin
      if (!reset_n) begin
         r_hist <= '1;
         r_held <= 1'b1;
      end else begin
         r_hist[0] <= r_sync;
         for (int i = 1; i < FILT_LEN-1; i++) begin
            r_hist[i] <= r_hist[i-1];
         end
         r_held <= w_level;
      end
   end

   always_comb begin
      w_all1  = &{r_hist, r_sync};
      w_all0  = ~|{r_hist, r_sync};
      w_level = r_held;
      if (w_all1) begin
         w_level = 1'b1;
      end else if (w_all0) begin
         w_level = 1'b0;
      end
   end
`else
   assign w_level = r_sync;
`endif

   always_ff @(posedge clk12 or negedge reset_n) begin
      if (!reset_n) begin
         r_prev <= 1'b1;
         r_rise <= 1'b0;
      end else begin
         r_prev <= w_level;
         r_rise <= w_level & ~r_prev;
      end
   end

   assign o_level = w_level;
   assign o_rise  = r_rise;

endmodule

// File: rtl/joy_serial_tx.sv
// Board-side serial joystick transmitter behaving like chained '165s (parallel load, shift on rise).
// Build option JOY_TX_FILTER_EN adds a glitch filter on both host strobes.
//
// state    | meaning
// ---------|-------------------------------------------------------------
// ST_IDLE  | after reset, no load seen yet; clock edges ignored
// ST_LOAD  | load asserted; shift register tracks live inputs
// ST_ARM   | load released while joy_clk high; wait for it to drop
// ST_SHIFT | shifting one bit per joy_clk rising edge
module joy_serial_tx
   import joy_serial_tx_pkg::*;
(
   input  logic             clk12,
   input  logic             reset_n,
   input  logic [JOY_W-1:0] joy1_n,
   input  logic [JOY_W-1:0] joy2_n,
   input  logic             joy_clk,
   input  logic             joy_load,
   output logic             joy_data,
   output logic             frame_done,
   output logic [CNT_W-1:0] bit_cnt
);

   logic w_clk_lvl;
   logic w_clk_rise;
   logic w_load_lvl;
   logic w_load_rise;

   tx_state_t r_state;
   tx_state_t w_state_nxt;
   logic      w_do_load;
   logic      w_do_shift;

   logic [FRAME_LEN-1:0] w_frame;
   logic [FRAME_LEN-1:0] r_shreg;
   logic [CNT_W-1:0]     r_bit_cnt;
   logic                 r_frame_done;

   joy_tx_sync u_sync_clk (
      .clk12   (clk12),
      .reset_n (reset_n),
      .i_async (joy_clk),
      .o_level (w_clk_lvl),
      .o_rise  (w_clk_rise)
   );

   joy_tx_sync u_sync_load (
      .clk12   (clk12),
      .reset_n (reset_n),
      .i_async (joy_load),
      .o_level (w_load_lvl),
      .o_rise  (w_load_rise)
   );

   always_ff @(posedge clk12 or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!w_load_lvl) begin
         w_state_nxt = ST_LOAD;
      end else begin
         case (r_state)
            ST_LOAD: begin
               if (w_load_rise) begin
                  w_state_nxt = w_clk_lvl ? ST_ARM : ST_SHIFT;
               end
            end
            ST_ARM: begin
               if (!w_clk_lvl) begin
                  w_state_nxt = ST_SHIFT;
               end
            end
            default: begin
               w_state_nxt = r_state;
            end
         endcase
      end
   end

   // Load has priority over a coincident clock edge.
   always_comb begin
      w_do_load  = !w_load_lvl;
      w_do_shift = w_load_lvl && w_clk_rise && (r_state == ST_SHIFT);
   end

   assign w_frame = build_frame(joy1_n, joy2_n);

   always_ff @(posedge clk12 or negedge reset_n) begin
      if (!reset_n) begin
         r_shreg      <= '1;
         r_bit_cnt    <= '0;
         r_frame_done <= 1'b0;
      end else if (w_do_load) begin
         r_shreg      <= w_frame;
         r_bit_cnt    <= '0;
         r_frame_done <= 1'b0;
      end else if (w_do_shift) begin
         r_shreg      <= {1'b1, r_shreg[FRAME_LEN-1:1]};
         r_frame_done <= (r_bit_cnt == CNT_LAST);
         if (r_bit_cnt != CNT_FULL) begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
         end
      end else begin
         r_frame_done <= 1'b0;
      end
   end

   assign joy_data   = r_shreg[0];
   assign frame_done = r_frame_done;
   assign bit_cnt    = r_bit_cnt;

endmodule

// File: tb/tb_joy_serial_tx.sv
// Bench for joy_serial_tx: host-side driver, expected-bit queue and a joy_clk-edge monitor.
module tb_joy_serial_tx;

   logic        clk12    = 1'b0;
   logic        reset_n  = 1'b0;
   logic [11:0] joy1_n   = '1;
   logic [11:0] joy2_n   = '1;
   logic        joy_clk  = 1'b0;
   logic        joy_load = 1'b1;
   logic        joy_data;
   logic        frame_done;
   logic [4:0]  bit_cnt;

   always #5 clk12 = ~clk12;

   joy_serial_tx dut (
      .clk12      (clk12),
      .reset_n    (reset_n),
      .joy1_n     (joy1_n),
      .joy2_n     (joy2_n),
      .joy_clk    (joy_clk),
      .joy_load   (joy_load),
      .joy_data   (joy_data),
      .frame_done (frame_done),
      .bit_cnt    (bit_cnt)
   );

   int          checks   = 0;
   int          errors   = 0;
   int          fd_count = 0;
   int          exp_fd   = 0;
   int          model_n  = 0;
   logic [23:0] model_f  = '1;
   bit          sb_en    = 1'b0;
   logic        sb_q[$];

   // Frame as the host sees it, MSB = last bit shifted out, LSB = first.
   function automatic logic [23:0] ref_frame(input logic [11:0] a, input logic [11:0] b);
      return {a[7], a[9], a[11], a[10],
              b[7], b[9], b[11], b[10],
              b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[8],
              a[0], a[1], a[2], a[3], a[4], a[5], a[6], a[8]};
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk12) begin
      if (frame_done) fd_count++;
   end

   always @(posedge joy_clk) begin
      if (sb_en) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL joy_data_bit: got %0d with no expected bit queued at %0t", joy_data, $time);
         end else begin
            chk("joy_data_bit", joy_data, sb_q.pop_front());
         end
      end
   end

   task automatic host_edge(input int hi, input int lo, input bit counts);
      logic e;
      e = (model_n < 24) ? model_f[model_n] : 1'b1;
      sb_q.push_back(e);
      @(negedge clk12);
      joy_clk = 1'b1;
      repeat (hi) @(negedge clk12);
      joy_clk = 1'b0;
      if (counts) begin
         if (model_n == 23) exp_fd++;
         if (model_n < 24) model_n++;
      end
      repeat (lo) @(negedge clk12);
      chk("bit_cnt", bit_cnt, model_n);
      chk("frame_done_count", fd_count, exp_fd);
   endtask

   task automatic release_load();
      model_f  = ref_frame(joy1_n, joy2_n);
      model_n  = 0;
      joy_load = 1'b1;
      repeat (8) @(negedge clk12);
      chk("bit_cnt_after_load", bit_cnt, 0);
      chk("first_bit_after_load", joy_data, model_f[0]);
      chk("fd_after_load", fd_count, exp_fd);
   endtask

   task automatic do_load(input int hold);
      @(negedge clk12);
      joy_load = 1'b0;
      repeat (hold) @(negedge clk12);
      release_load();
   endtask

   task automatic run_frame(input int n_edges, input bit scramble);
      for (int i = 0; i < n_edges; i++) begin
         host_edge(int'($urandom_range(3, 6)), int'($urandom_range(6, 9)), 1'b1);
         if (scramble && i == n_edges / 2) begin
            joy1_n = 12'($urandom);
            joy2_n = 12'($urandom);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset held with toggling strobes
      for (int i = 0; i < 16; i++) begin
         @(negedge clk12);
         joy_clk  = ~joy_clk;
         joy_load = i[1];
         chk("reset_joy_data", joy_data, 1);
         chk("reset_bit_cnt", bit_cnt, 0);
         chk("reset_frame_done", frame_done, 0);
      end
      joy_clk  = 1'b0;
      joy_load = 1'b1;
      @(negedge clk12);
      reset_n = 1'b1;
      sb_en   = 1'b1;
      repeat (4) @(negedge clk12);

      // Directed full frame
      joy1_n = 12'hFFE;
      joy2_n = 12'h7FF;
      do_load(6);
      run_frame(24, 1'b0);

      // Over-clock past the frame
      do_load(6);
      run_frame(30, 1'b0);

      // Abort after 10 edges, then a clean frame
      joy1_n = 12'($urandom);
      joy2_n = 12'($urandom);
      do_load(5);
      run_frame(10, 1'b0);
      joy1_n = 12'($urandom);
      joy2_n = 12'($urandom);
      do_load(5);
      run_frame(24, 1'b0);

      // Hold load: live tracking, clock edges ignored
      @(negedge clk12);
      joy_load = 1'b0;
      repeat (6) @(negedge clk12);
      model_n = 0;
      for (int k = 0; k < 4; k++) begin
         joy1_n[8] = ~joy1_n[8];
         model_f   = ref_frame(joy1_n, joy2_n);
         repeat (3) @(posedge clk12);
         #1;
         chk("load_transparent", joy_data, joy1_n[8]);
         host_edge(4, 6, 1'b0);
      end
      release_load();
      run_frame(24, 1'b0);

      // Short joy_clk pulse, then a 3-cycle pulse
      joy1_n = 12'($urandom);
      joy2_n = 12'($urandom);
      do_load(6);
`ifdef JOY_TX_FILTER_EN
      host_edge(1, 8, 1'b0);
`else
      host_edge(1, 8, 1'b1);
`endif
      host_edge(3, 8, 1'b1);

      // Reset in the middle of a frame
      run_frame(5, 1'b0);
      @(negedge clk12);
      #2 reset_n = 1'b0;
      #1;
      chk("midreset_joy_data", joy_data, 1);
      chk("midreset_bit_cnt", bit_cnt, 0);
      chk("midreset_frame_done", frame_done, 0);
      @(negedge clk12);
      chk("midreset_hold_joy_data", joy_data, 1);
      reset_n = 1'b1;
      repeat (4) @(negedge clk12);
      do_load(6);
      run_frame(24, 1'b0);

      // Randomized frames with input changes during shifting
      for (int f = 0; f < 6; f++) begin
         joy1_n = 12'($urandom);
         joy2_n = 12'($urandom);
         do_load(int'($urandom_range(4, 8)));
         run_frame(int'($urandom_range(20, 30)), 1'b1);
      end

      repeat (4) @(negedge clk12);
      chk("scoreboard_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
